// File: rtl/line_backing_store.sv
// Line-granular backing store behind the L1 arbiter: persistent 128-bit lines,
// fixed-latency in-order read responses tagged with the requesting client.
module line_backing_store #(
    parameter int           LATENCY      = 5,
    parameter int           ADDR_BITS    = 8,
    parameter logic [127:0] FILL_PATTERN = 128'hFB63DA9647CC13DC9913FA22DEADBEEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         rden,
    input  logic         wren,
    input  logic [31:0]  addr_in,
    input  logic [127:0] data_in,
    input  logic         client_id_in,
    output logic [127:0] data_out,
    output logic         data_out_valid,
    output logic         client_id_out,
    output logic         busy,
    output logic [31:0]  rd_count,
    output logic [31:0]  wr_count
);

    localparam int LINES = 1 << ADDR_BITS;

    logic [ADDR_BITS-1:0]         idx;
    logic [127:0]                 mem [LINES];
    logic [LINES-1:0]             written;
    logic [127:0]                 rd_value;
    logic                         accept;

    // Stages 1..LATENCY-1; the output registers form the final stage.
    logic [LATENCY-2:0]           vld_p;
    logic [LATENCY-2:0]           cid_p;
    logic [LATENCY-2:0][127:0]    dat_p;

    logic                         unused_addr;

    function automatic logic [127:0] fill_value(input logic [ADDR_BITS-1:0] line);
        return FILL_PATTERN ^ {4{32'(line)}};
    endfunction

    assign idx         = addr_in[ADDR_BITS+3:4];
    assign unused_addr = ^{addr_in[31:ADDR_BITS+4], addr_in[3:0]};
    assign accept      = en && !reset;
    assign busy        = (|vld_p) || data_out_valid;

    // A single address port means a simultaneous write always targets the line
    // being read, so the write-first bypass needs no index compare.
    always_comb begin
        rd_value = fill_value(idx);
        if (wren)
            rd_value = data_in;
        else if (written[idx])
            rd_value = mem[idx];
    end

    // Control: valid bits, written mask, output stage and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p          <= '0;
            written        <= '0;
            data_out_valid <= 1'b0;
            data_out       <= '0;
            client_id_out  <= 1'b0;
            rd_count       <= '0;
            wr_count       <= '0;
        end else if (en) begin
            vld_p[0] <= rden;
            for (int i = 1; i < LATENCY - 1; i++)
                vld_p[i] <= vld_p[i-1];
            data_out_valid <= vld_p[LATENCY-2];
            if (vld_p[LATENCY-2]) begin
                data_out      <= dat_p[LATENCY-2];
                client_id_out <= cid_p[LATENCY-2];
            end
            if (wren) begin
                written[idx] <= 1'b1;
                wr_count     <= wr_count + 32'd1;
            end
            if (rden)
                rd_count <= rd_count + 32'd1;
        end
    end

    // Data path: payload shifts with the valid bits; contents are qualified by vld_p.
    always_ff @(posedge clk) begin
        if (en) begin
            dat_p[0] <= rd_value;
            cid_p[0] <= client_id_in;
            for (int i = 1; i < LATENCY - 1; i++) begin
                dat_p[i] <= dat_p[i-1];
                cid_p[i] <= cid_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && wren)
            mem[idx] <= data_in;
    end

endmodule

// File: tb/tb_line_backing_store.sv
// Directed bench for line_backing_store: reset state, fill patterns, write
// persistence, write-first bypass, ordering, en freeze and mid-flight reset.
module tb_line_backing_store;

    localparam int LAT = 5;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic         rden = 1'b0;
    logic         wren = 1'b0;
    logic [31:0]  addr_in = '0;
    logic [127:0] data_in = '0;
    logic         client_id_in = 1'b0;
    logic [127:0] data_out;
    logic         data_out_valid;
    logic         client_id_out;
    logic         busy;
    logic [31:0]  rd_count;
    logic [31:0]  wr_count;

    int checks = 0;
    int failures = 0;
    int exp_rd = 0;
    int exp_wr = 0;

    localparam logic [127:0] FILL   = 128'hFB63DA96_47CC13DC_9913FA22_DEADBEEF;
    localparam logic [127:0] PAT_01 = 128'hFB63DA97_47CC13DD_9913FA23_DEADBEEE;
    localparam logic [127:0] PAT_02 = 128'hFB63DA94_47CC13DE_9913FA20_DEADBEED;
    localparam logic [127:0] PAT_03 = 128'hFB63DA95_47CC13DF_9913FA21_DEADBEEC;
    localparam logic [127:0] PAT_05 = 128'hFB63DA93_47CC13D9_9913FA27_DEADBEEA;
    localparam logic [127:0] PAT_06 = 128'hFB63DA90_47CC13DA_9913FA24_DEADBEE9;
    localparam logic [127:0] PAT_10 = 128'hFB63DA86_47CC13CC_9913FA32_DEADBEFF;

    typedef struct {
        logic [31:0]  addr;
        logic         cid;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [7];

    line_backing_store #(.LATENCY(LAT), .ADDR_BITS(8)) dut (
        .clk(clk), .reset(reset), .en(en), .rden(rden), .wren(wren),
        .addr_in(addr_in), .data_in(data_in), .client_id_in(client_id_in),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .client_id_out(client_id_out), .busy(busy),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic req(input bit rd, input bit wr, input logic [31:0] a,
                       input bit c, input logic [127:0] d);
        rden = rd; wren = wr; addr_in = a; client_id_in = c; data_in = d;
        step();
        if (en) begin
            exp_rd += int'(rd);
            exp_wr += int'(wr);
        end
        rden = 1'b0; wren = 1'b0;
    endtask

    // Call right after the edge that sampled the read.
    task automatic expect_resp(input string nm, input bit c, input logic [127:0] d);
        for (int i = 0; i < LAT - 1; i++) begin
            chk({nm, "_early"}, 128'(data_out_valid), 128'(1'b0));
            step();
        end
        chk({nm, "_valid"}, 128'(data_out_valid), 128'(1'b1));
        chk({nm, "_data"}, data_out, d);
        chk({nm, "_cid"}, 128'(client_id_out), 128'(c));
    endtask

    task automatic chk_counts(input string nm);
        chk({nm, "_rd_count"}, 128'(rd_count), 128'(exp_rd));
        chk({nm, "_wr_count"}, 128'(wr_count), 128'(exp_wr));
    endtask

    initial begin
        tbl[0] = '{32'h0000_0010, 1'b0, PAT_01};
        tbl[1] = '{32'h0000_0020, 1'b1, PAT_02};
        tbl[2] = '{32'h0000_0030, 1'b0, PAT_03};
        tbl[3] = '{32'h0000_1018, 1'b1, PAT_01};       // aliases line 1
        tbl[4] = '{32'hFFFF_F000, 1'b0, FILL};         // line 0
        tbl[5] = '{32'h0000_0100, 1'b1, 128'hDEADBEEF};
        tbl[6] = '{32'h0000_0200, 1'b0, 128'h5678};

        // Reset state
        step(); step();
        chk("rst_valid", 128'(data_out_valid), 128'(1'b0));
        chk("rst_data", data_out, 128'h0);
        chk("rst_cid", 128'(client_id_out), 128'(1'b0));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk_counts("rst");
        reset = 1'b0;
        en = 1'b1;
        step();

        // Never-written line returns the fill pattern
        req(1, 0, 32'h100, 0, '0);
        chk("rd1_busy", 128'(busy), 128'(1'b1));
        expect_resp("rd1", 1'b0, PAT_10);
        chk_counts("rd1");
        step();
        chk("rd1_drop", 128'(data_out_valid), 128'(1'b0));
        chk("rd1_hold", data_out, PAT_10);
        chk("rd1_idle", 128'(busy), 128'(1'b0));

        // Write persists
        req(0, 1, 32'h100, 0, 128'hDEADBEEF);
        req(1, 0, 32'h100, 1, '0);
        expect_resp("wr_rd", 1'b1, 128'hDEADBEEF);
        chk_counts("wr_rd");
        step();

        // Simultaneous read and write: write-first
        req(1, 1, 32'h200, 0, 128'h1234);
        expect_resp("bypass", 1'b0, 128'h1234);
        step();

        // Write after the sampling edge does not affect the in-flight read
        req(1, 0, 32'h200, 1, '0);
        req(0, 1, 32'h200, 0, 128'h5678);
        for (int i = 0; i < LAT - 2; i++) step();
        chk("later_wr_valid", 128'(data_out_valid), 128'(1'b1));
        chk("later_wr_data", data_out, 128'h1234);
        chk_counts("later_wr");
        step();

        // Back-to-back reads from the table, responses in issue order
        for (int s = 0; s < 7 + LAT - 1; s++) begin
            if (s < 7) begin
                rden = 1'b1; addr_in = tbl[s].addr; client_id_in = tbl[s].cid;
            end else begin
                rden = 1'b0;
            end
            step();
            if (s < 7) exp_rd++;
            if (s >= LAT - 1) begin
                chk($sformatf("tbl%0d_valid", s - LAT + 1), 128'(data_out_valid), 128'(1'b1));
                chk($sformatf("tbl%0d_data", s - LAT + 1), data_out, tbl[s - LAT + 1].exp);
                chk($sformatf("tbl%0d_cid", s - LAT + 1), 128'(client_id_out), 128'(tbl[s - LAT + 1].cid));
            end else begin
                chk($sformatf("tbl_pre%0d_valid", s), 128'(data_out_valid), 128'(1'b0));
            end
        end
        rden = 1'b0;
        step();
        chk("tbl_done_valid", 128'(data_out_valid), 128'(1'b0));
        chk("tbl_done_busy", 128'(busy), 128'(1'b0));
        chk_counts("tbl");

        // en freeze: three stalled edges delay the response by three cycles
        req(1, 0, 32'h60, 0, '0);
        step();
        en = 1'b0; rden = 1'b1; wren = 1'b1; addr_in = 32'h70; data_in = 128'hBAD;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_busy", 128'(busy), 128'(1'b1));
            chk("frz_valid", 128'(data_out_valid), 128'(1'b0));
        end
        rden = 1'b0; wren = 1'b0; en = 1'b1;
        chk_counts("frz");
        step();
        step();
        chk("frz_late", 128'(data_out_valid), 128'(1'b0));
        step();
        chk("frz_valid_out", 128'(data_out_valid), 128'(1'b1));
        chk("frz_data", data_out, PAT_06);
        en = 1'b0;
        step();
        chk("frz_valid_held", 128'(data_out_valid), 128'(1'b1));
        en = 1'b1;
        step();
        chk("frz_valid_drop", 128'(data_out_valid), 128'(1'b0));
        req(1, 0, 32'h70, 1, '0);
        expect_resp("frz_dropped_wr", 1'b1, 128'hFB63DA91_47CC13DB_9913FA25_DEADBEE8);
        step();

        // Reset with a read in flight
        req(0, 1, 32'h50, 0, 128'hCAFE);
        req(1, 0, 32'h50, 0, '0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_rd = 0; exp_wr = 0;
        chk("mid_rst_busy", 128'(busy), 128'(1'b0));
        chk("mid_rst_valid", 128'(data_out_valid), 128'(1'b0));
        chk_counts("mid_rst");
        for (int i = 0; i < LAT + 1; i++) begin
            step();
            chk("mid_rst_no_resp", 128'(data_out_valid), 128'(1'b0));
        end
        req(1, 0, 32'h50, 1, '0);
        expect_resp("mid_rst_reread", 1'b1, PAT_05);
        chk_counts("mid_rst_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
